// File: rtl/calculator_pkg.sv
// Shared stage encodings for the calculator front end.
//
// Used by the stage selector here and by the downstream capture and display
// logic, so that every block agrees on what each OUT_stage value means.
//   STAGE_NUM1   = 0 : waiting for operand 1
//   STAGE_NUM2   = 1 : waiting for operand 2
//   STAGE_OP     = 2 : waiting for the operation code
//   STAGE_RESULT = 3 : result on display
package calculator_pkg;

  localparam logic [1:0] STAGE_NUM1   = 2'd0;
  localparam logic [1:0] STAGE_NUM2   = 2'd1;
  localparam logic [1:0] STAGE_OP     = 2'd2;
  localparam logic [1:0] STAGE_RESULT = 2'd3;

  typedef enum logic [1:0] {
    S_NUM1   = STAGE_NUM1,
    S_NUM2   = STAGE_NUM2,
    S_OP     = STAGE_OP,
    S_RESULT = STAGE_RESULT
  } stage_t;

  // Forward step used when a store pulse completes (never called from RESULT).
  function automatic stage_t next_stage(stage_t s);
    case (s)
      S_NUM1:  next_stage = S_NUM2;
      S_NUM2:  next_stage = S_OP;
      default: next_stage = S_RESULT;
    endcase
  endfunction

  // Backward step for the optional back button (never called from NUM1).
  function automatic stage_t prev_stage(stage_t s);
    case (s)
      S_RESULT: prev_stage = S_OP;
      S_OP:     prev_stage = S_NUM2;
      default:  prev_stage = S_NUM1;
    endcase
  endfunction

endpackage

// File: rtl/calculator_stage_selector_if.sv
// Button and status bundle between the stage selector and its surroundings.
//
// Signals:
//   IN_next_button            raw "next" button, high = pressed
//   IN_back_button            raw "back" button (only used with STAGE_BACK_EN)
//   OUT_store_num1            store pulse for operand 1
//   OUT_store_num2            store pulse for operand 2
//   OUT_store_operation_code  store pulse for the opcode
//   OUT_stage                 current stage (calculator_pkg encodings)
//   OUT_show_result           high while in the RESULT stage
//   OUT_new_calc              one-cycle pulse on RESULT -> NUM1
//   OUT_busy                  high while any store pulse is active
// Modports:
//   master : the side that drives the buttons and watches the status
//   slave  : the stage selector itself
interface calculator_stage_selector_if;

  logic       IN_next_button;
  logic       IN_back_button;
  logic       OUT_store_num1;
  logic       OUT_store_num2;
  logic       OUT_store_operation_code;
  logic [1:0] OUT_stage;
  logic       OUT_show_result;
  logic       OUT_new_calc;
  logic       OUT_busy;

  modport master (
    output IN_next_button, IN_back_button,
    input  OUT_store_num1, OUT_store_num2, OUT_store_operation_code,
    input  OUT_stage, OUT_show_result, OUT_new_calc, OUT_busy
  );

  modport slave (
    input  IN_next_button, IN_back_button,
    output OUT_store_num1, OUT_store_num2, OUT_store_operation_code,
    output OUT_stage, OUT_show_result, OUT_new_calc, OUT_busy
  );

endinterface

// File: rtl/calculator_stage_selector_debouncer.sv
// button_debouncer: synchroniser + debouncer + press detector for one button.
//
// Ports:
//   IN_clk     system clock
//   IN_reset   synchronous active-high reset
//   IN_button  raw asynchronous, bouncing button (high = pressed)
//   OUT_level  accepted (debounced) button level
//   OUT_press  one-cycle pulse on the accepted 0->1 transition
//
// The accepted level changes only after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts
// the count. OUT_press is asserted in the same cycle OUT_level first reads 1.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic IN_clk,
  input  logic IN_reset,
  input  logic IN_button,
  output logic OUT_level,
  output logic OUT_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], IN_button};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th disagreeing cycle: accept it.
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign OUT_level = level_reg;
  assign OUT_press = press_reg;

endmodule

// File: rtl/calculator_stage_selector.sv
// calculator_stage_selector: sequencer in front of the calculator capture
// stage.
//
// Debounces the "next" button and steps NUM1 -> NUM2 -> OP -> RESULT -> NUM1.
// In the three entry stages a press fires a STORE_PULSE_CYCLES-wide store
// pulse on the matching line; the stage advances on the edge where that pulse
// falls. In RESULT a press returns to NUM1 with a one-cycle OUT_new_calc.
// Presses arriving while a store pulse is active are dropped.
//
// Ports:
//   IN_clk    system clock
//   IN_reset  synchronous active-high reset
//   bus       calculator_stage_selector_if.slave (buttons in, status out)
//
// Optional build macro STAGE_BACK_EN: adds a debounced back button that steps
// RESULT->OP, OP->NUM2, NUM2->NUM1 when idle; next wins over a simultaneous
// back. Without the macro IN_back_button is ignored.
module calculator_stage_selector
  import calculator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int STORE_PULSE_CYCLES = 4
) (
  input  logic                         IN_clk,
  input  logic                         IN_reset,
  calculator_stage_selector_if.slave   bus
);

  localparam int PW = $clog2(STORE_PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(STORE_PULSE_CYCLES);

  logic          next_press;
  logic          next_level_unused;
  logic          back_press;
  stage_t        state_reg;
  logic [2:0]    store_reg;   // one-hot by stage: [0]=num1 [1]=num2 [2]=op
  logic [PW-1:0] pulse_cnt_reg;
  logic          new_calc_reg;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_next_debouncer (
    .IN_clk    (IN_clk),
    .IN_reset  (IN_reset),
    .IN_button (bus.IN_next_button),
    .OUT_level (next_level_unused),
    .OUT_press (next_press)
  );

`ifdef STAGE_BACK_EN
  logic back_level_unused;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_back_debouncer (
    .IN_clk    (IN_clk),
    .IN_reset  (IN_reset),
    .IN_button (bus.IN_back_button),
    .OUT_level (back_level_unused),
    .OUT_press (back_press)
  );
`else
  logic back_button_unused;
  assign back_button_unused = bus.IN_back_button;
  assign back_press         = 1'b0;
`endif

  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      state_reg     <= S_NUM1;
      store_reg     <= 3'b000;
      pulse_cnt_reg <= '0;
      new_calc_reg  <= 1'b0;
    end else begin
      new_calc_reg <= 1'b0;
      if (store_reg != 3'b000) begin
        // Pulse in progress: every button event in this window is discarded.
        if (pulse_cnt_reg == PULSE_LAST) begin
          store_reg     <= 3'b000;
          pulse_cnt_reg <= '0;
          state_reg     <= next_stage(state_reg);
        end else begin
          pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
        end
      end else if (next_press) begin
        if (state_reg == S_RESULT) begin
          state_reg    <= S_NUM1;
          new_calc_reg <= 1'b1;
        end else begin
          store_reg     <= 3'b001 << state_reg;
          pulse_cnt_reg <= PW'(1);
        end
      end else if (back_press && state_reg != S_NUM1) begin
        state_reg <= prev_stage(state_reg);
      end
    end
  end

  assign bus.OUT_store_num1           = store_reg[0];
  assign bus.OUT_store_num2           = store_reg[1];
  assign bus.OUT_store_operation_code = store_reg[2];
  assign bus.OUT_stage                = state_reg;
  assign bus.OUT_show_result          = (state_reg == S_RESULT);
  assign bus.OUT_new_calc             = new_calc_reg;
  assign bus.OUT_busy                 = |store_reg;

endmodule

// File: doc/calculator_stage_selector.md
Name: calculator_stage_selector

Overview:
- Upstream sequencer for the calculator datapath capture stage.
- Synchronises and debounces the raw "next" push-button, steps a 4-stage FSM (enter num1 -> enter num2 -> enter operation -> show result).
- Emits the multi-cycle store pulses whose rising edges latch switches and opcode into the capture registers downstream.
- Also drives stage/status outputs for display logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised button must be stable before its level is accepted (10 ms at 100 MHz); legal range >= 2.
- STORE_PULSE_CYCLES, 4, width in clock cycles of every OUT_store_* pulse; legal range >= 1.

Ports:
- IN_clk  input  1  system clock; all state updates on its rising edge.
- IN_reset  input  1  synchronous, active-high reset.
- IN_next_button  input  1  raw, asynchronous, bouncing "next" button; high = pressed.
- IN_back_button  input  1  raw "back" button; used only with STAGE_BACK_EN, otherwise ignored.
- OUT_store_num1  output  1  store pulse for operand 1.
- OUT_store_num2  output  1  store pulse for operand 2.
- OUT_store_operation_code  output  1  store pulse for opcode.
- OUT_stage  output  2  current stage: 0 NUM1, 1 NUM2, 2 OP, 3 RESULT.
- OUT_show_result  output  1  high while in RESULT.
- OUT_new_calc  output  1  one-cycle pulse when RESULT -> NUM1.
- OUT_busy  output  1  high while any store pulse is active.

Behaviour:
- Synchroniser: two flops per button input; reset clears them to 0.
- Debounce: counter restarts whenever the synchronised level differs from the accepted level. When the level has differed for DEBOUNCE_CYCLES consecutive cycles, the accepted level updates and the counter clears.
- Press event: a 1-cycle internal event fires on the accepted-level 0->1 transition. Release produces no event. Holding the button gives exactly one event.
- FSM states: S_NUM1, S_NUM2, S_OP, S_RESULT. OUT_stage is the state encoding, registered.
- On a press event in S_NUM1, S_NUM2 or S_OP with no pulse active:
  - The matching OUT_store_* line rises the next cycle.
  - It stays high exactly STORE_PULSE_CYCLES cycles.
  - The state advances on the cycle the pulse falls, so OUT_stage changes together with the pulse falling.
- On a press event in S_RESULT: the next cycle the state goes to S_NUM1 and OUT_new_calc is high for 1 cycle. No store pulse.
- Events arriving while OUT_busy=1 are dropped, never queued.
- At most one OUT_store_* is high at any time.
- OUT_busy equals the OR of the three store lines.
- Pulse counter width: clog2(STORE_PULSE_CYCLES+1). Debounce counter width: clog2(DEBOUNCE_CYCLES+1). Neither counter wraps; both saturate or clear as described.
- Reset values, all 0: every output, debounce state, accepted levels and counters. State = S_NUM1 (OUT_stage=0).
- Reset mid-pulse: the pulse drops in the same cycle reset is sampled and the state returns to S_NUM1. The downstream register keeps whatever its rising edge captured.
- Button held through reset: after reset the accepted level is 0. The still-pressed button therefore produces one event after DEBOUNCE_CYCLES.

Optional Feature:
- Macro: STAGE_BACK_EN.
- Defined: IN_back_button gets its own synchroniser and debouncer with the same parameter.
  - A back press event with no pulse active moves S_NUM2->S_NUM1, S_OP->S_NUM2, S_RESULT->S_OP on the next cycle. No store pulse is issued.
  - Back in S_NUM1 is ignored.
  - Simultaneous next and back events: next wins, back is dropped.
- Not defined: IN_back_button is unconnected internally and no back logic is synthesised. Behaviour is identical to the base FSM.

Decomposition:
- Package calculator_pkg holds the stage encodings (STAGE_NUM1=2'd0, STAGE_NUM2=2'd1, STAGE_OP=2'd2, STAGE_RESULT=2'd3). Display logic and capture logic share it.
- Sub-module button_debouncer:
  - Contains the 2-flop synchroniser, stability counter, accepted level and rise-event output.
  - Parameter DEBOUNCE_CYCLES; ports IN_clk, IN_reset, IN_button, OUT_level, OUT_press.
  - Instantiated once, or twice with STAGE_BACK_EN.

Test Plan (DEBOUNCE_CYCLES=4, STORE_PULSE_CYCLES=3):
- Reset, then hold next high 10 cycles -> one event. OUT_store_num1 high for exactly 3 cycles; OUT_stage 0->1 on the falling cycle; other store lines stay 0.
- Next toggles every 2 cycles for 20 cycles (bounce), then low -> no event, OUT_stage stays 0, all outputs 0.
- Four clean presses -> pulses on num1, then num2, then operation_code. OUT_stage goes 1, 2, 3; OUT_show_result=1 at stage 3. The fourth press gives OUT_new_calc for 1 cycle and OUT_stage=0.
- Second debounced press landing while OUT_busy=1 -> dropped; only one 3-cycle pulse; stage advances by one.
- Assert IN_reset on the 2nd cycle of an OUT_store_num2 pulse -> pulse low that cycle, OUT_stage=0, all outputs 0.
- With STAGE_BACK_EN: in stage 2 press back -> stage 1, no pulse. Next and back events in the same cycle at stage 1 -> num2 pulse, then stage 2. Back at stage 0 -> no change.
